dds_phase_gen: RTL and testbench
================================

// Module: dds_phase_gen
// PURPOSE
//  Per-player phase accumulator that produces the THETA_WIDTH phase words consumed by the DDS sine lookup.
//  Divides clk down to the audio sample rate. On each sample tick, adds each gated player's frequency control word to its accumulator.
//  Presents the accumulator MSBs as theta, bus-compatible with the DDS lookup input.
//  Sits between the note/key decoder (fcw, gate, retrig) and the DDS table.
// PARAMETERS
//  PLAYER_NUM   3     number of independent voices
//  THETA_WIDTH  8     phase word width to DDS; must be <= ACC_WIDTH
//  ACC_WIDTH    24    accumulator width; wraps modulo 2^ACC_WIDTH
//  FCW_WIDTH    16    frequency control word width; must be <= ACC_WIDTH
//  CLK_DIV      2500  clk cycles per sample tick; must be >= 2
// PORTS
//  clk         in   1                     system clock; all logic on rising edge
//  rst_n       in   1                     synchronous, active-low reset
//  fcw         in   FCW_WIDTH*PLAYER_NUM  per-player phase increment; player i at [FCW_WIDTH*i +: FCW_WIDTH]
//  gate        in   PLAYER_NUM            level; 1 = player i sounding
//  retrig      in   PLAYER_NUM            1-cycle pulse; forces player i phase to 0
//  theta       out  THETA_WIDTH*PLAYER_NUM phase to DDS; player i at [THETA_WIDTH*i +: THETA_WIDTH]
//  theta_valid out  1                     1-cycle pulse; new theta on all players this cycle
//  active      out  PLAYER_NUM            gate as sampled at the last tick
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - div counter, all accumulators, theta, theta_valid and active go to 0.
//   - Reset mid-operation discards all phase; the counter restarts from 0.
//  Tick:
//   - div counter counts 0..CLK_DIV-1, then wraps.
//   - tick = (counter == CLK_DIV-1); the first tick is the CLK_DIV-th edge after reset release.
//  At the tick edge, per player i:
//   - retrig[i]=1 -> acc = 0 (retrig wins over accumulate).
//   - else gate[i]=0 -> acc = 0 (silent voice holds phase 0).
//   - else -> acc = acc + zero_ext(fcw_i), modulo 2^ACC_WIDTH (carry dropped, no saturation).
//   - active[i] <= gate[i]; theta_valid <= 1.
//  Off-tick edge, per player i:
//   - retrig[i]=1 -> acc = 0; otherwise acc holds.
//   - theta_valid <= 0. A retrig alone never pulses theta_valid.
//  fcw and gate are sampled only at tick edges. Changes between ticks are invisible until the next tick.
//  theta_i = acc_i[ACC_WIDTH-1 -: THETA_WIDTH], registered with acc, so there is no added latency beyond acc.
//  theta_valid is high in exactly the cycle in which post-tick theta is first visible.
//  First tick after gate rise (acc=0): theta = MSBs of fcw.
//  All players update on the same edge. Player order is irrelevant; there is no shared resource.
// STRUCTURE
//  Shared include piano_defs.vh:
//   - PLAYER_NUM, THETA_WIDTH, ACC_WIDTH, FCW_WIDTH defaults.
//   - Clock/sample-rate constant used to derive CLK_DIV.
//   - Shared with the DDS lookup so widths match.
//  Sub-module phase_acc: one accumulator plus retrig/gate mux, instantiated PLAYER_NUM times in a generate loop.
//  Divider and theta_valid live in the top level.
// TESTING (bench uses CLK_DIV=4, ACC_WIDTH=24, FCW_WIDTH=16, THETA_WIDTH=8)
//  1. Reset: rst_n=0 for 5 cycles, then release.
//     -> all outputs 0 during reset; first theta_valid pulse on the 4th edge after release, then every 4 cycles.
//  2. Accumulate: fcw0=0x1000, gate0=1.
//     -> acc0=0x001000 after tick 1 (theta0=0x00); theta0=0x01 after tick 16.
//     -> players 1,2 (gate=0) stay theta=0, active=3'b001.
//  3. Wrap: fcw0=0x8000, gate0=1.
//     -> theta0=0xFF after tick 511; theta0=0x00 after tick 512 (acc 0x000000, carry dropped).
//  4. Retrig: pulse retrig0 2 cycles before a tick.
//     -> theta0=0 next cycle, theta_valid stays 0; next tick gives theta0=0x00 with acc=fcw0.
//     -> retrig0 coincident with a tick gives theta0=0 and acc=0 (not fcw0).
//  5. Gate/fcw sampling: change fcw0 from 0x1000 to 0x4000 mid-interval.
//     -> old increment used until the next tick.
//     -> gate0 dropped 1 cycle before a tick: acc0=0 and active[0]=0 at that tick.
//  6. Reset mid-operation: rst_n=0 for 1 cycle with theta0=0x5A, counter=2.
//     -> theta, active, theta_valid all 0; next theta_valid 4 cycles after release.

Source files
------------

// File: rtl/dds_phase_gen_pkg.sv
// rtl/dds_phase_gen_pkg.sv - shared widths, sample-rate constants and accumulator op decode for the DDS phase generator
package dds_phase_gen_pkg;

    localparam int PLAYER_NUM_DEF  = 3;
    localparam int THETA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF   = 24;
    localparam int FCW_WIDTH_DEF   = 16;

    // The DDS lookup is built against the same clock and sample rate, so the divider stays in step with it.
    localparam int CLK_HZ      = 50_000_000;
    localparam int SAMPLE_HZ   = 20_000;
    localparam int CLK_DIV_DEF = CLK_HZ / SAMPLE_HZ;

    typedef enum logic [1:0] {
        ACC_HOLD  = 2'd0,
        ACC_CLEAR = 2'd1,
        ACC_STEP  = 2'd2
    } acc_op_e;

    // Retrig beats everything; a silent voice parks at phase 0 on each tick.
    function automatic acc_op_e acc_op(input logic tick, input logic gate, input logic retrig);
        if (retrig)
            return ACC_CLEAR;
        else if (!tick)
            return ACC_HOLD;
        else if (!gate)
            return ACC_CLEAR;
        else
            return ACC_STEP;
    endfunction

endpackage

// File: rtl/dds_phase_gen_phase_acc.sv
// rtl/dds_phase_gen_phase_acc.sv - one voice's phase accumulator with retrig/gate control
module dds_phase_gen_phase_acc
    import dds_phase_gen_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int FCW_WIDTH   = FCW_WIDTH_DEF,
    parameter int THETA_WIDTH = THETA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [FCW_WIDTH-1:0]   fcw,
    input  logic                   gate,
    input  logic                   retrig,
    output logic [THETA_WIDTH-1:0] theta
);

    logic [ACC_WIDTH-1:0] acc;

    // Carry out of the top bit is dropped so the phase wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            case (acc_op(tick, gate, retrig))
                ACC_CLEAR: acc <= '0;
                ACC_STEP:  acc <= acc + ACC_WIDTH'(fcw);
                default:   acc <= acc;
            endcase
        end
    end

    assign theta = acc[ACC_WIDTH-1 -: THETA_WIDTH];

endmodule

// File: rtl/dds_phase_gen.sv
// rtl/dds_phase_gen.sv - sample-rate divider and per-player phase accumulators feeding the DDS lookup
module dds_phase_gen
    import dds_phase_gen_pkg::*;
#(
    parameter int PLAYER_NUM  = PLAYER_NUM_DEF,
    parameter int THETA_WIDTH = THETA_WIDTH_DEF,
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int FCW_WIDTH   = FCW_WIDTH_DEF,
    parameter int CLK_DIV     = CLK_DIV_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [FCW_WIDTH*PLAYER_NUM-1:0]   fcw,
    input  logic [PLAYER_NUM-1:0]             gate,
    input  logic [PLAYER_NUM-1:0]             retrig,
    output logic [THETA_WIDTH*PLAYER_NUM-1:0] theta,
    output logic                              theta_valid,
    output logic [PLAYER_NUM-1:0]             active
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            theta_valid <= 1'b0;
            active      <= '0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + CNT_W'(1);
            theta_valid <= tick;
            if (tick)
                active <= gate;
        end
    end

    for (genvar i = 0; i < PLAYER_NUM; i++) begin : g_player
        dds_phase_gen_phase_acc #(
            .ACC_WIDTH   (ACC_WIDTH),
            .FCW_WIDTH   (FCW_WIDTH),
            .THETA_WIDTH (THETA_WIDTH)
        ) u_acc (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick   (tick),
            .fcw    (fcw[FCW_WIDTH*i +: FCW_WIDTH]),
            .gate   (gate[i]),
            .retrig (retrig[i]),
            .theta  (theta[THETA_WIDTH*i +: THETA_WIDTH])
        );
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// tb/tb_dds_phase_gen.sv - self-checking bench for dds_phase_gen: constant vectors, corner sequences, random vs model
module tb_dds_phase_gen;

    localparam int PN  = 3;
    localparam int TW  = 8;
    localparam int AW  = 24;
    localparam int FW  = 16;
    localparam int DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FW*PN-1:0]  fcw;
    logic [PN-1:0]     gate;
    logic [PN-1:0]     retrig;
    logic [TW*PN-1:0]  theta;
    logic              theta_valid;
    logic [PN-1:0]     active;

    int n_cmp  = 0;
    int n_fail = 0;

    dds_phase_gen #(
        .PLAYER_NUM (PN),
        .THETA_WIDTH(TW),
        .ACC_WIDTH  (AW),
        .FCW_WIDTH  (FW),
        .CLK_DIV    (DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fcw        (fcw),
        .gate       (gate),
        .retrig     (retrig),
        .theta      (theta),
        .theta_valid(theta_valid),
        .active     (active)
    );

    always #5 clk = ~clk;

    // Reference: count edges since reset release, tick on every DIV-th one, phase as plain modular arithmetic.
    int          m_edges = 0;
    longint      m_phase [PN];
    logic        m_tv = 1'b0;
    logic [PN-1:0] m_active = '0;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            m_edges = 0;
            for (int i = 0; i < PN; i++) m_phase[i] = 0;
            m_tv = 1'b0;
            m_active = '0;
        end else begin
            m_edges = m_edges + 1;
            m_tv = (m_edges % DIV == 0);
            for (int i = 0; i < PN; i++) begin
                if (retrig[i])
                    m_phase[i] = 0;
                else if (m_tv)
                    m_phase[i] = gate[i] ? (m_phase[i] + longint'(fcw[FW*i +: FW])) % (longint'(1) << AW) : 0;
            end
            if (m_tv) m_active = gate;
        end
    end

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < PN; i++)
            ck($sformatf("model_theta%0d", i), 32'(theta[TW*i +: TW]), 32'(m_phase[i] >> (AW - TW)));
        ck("model_valid", 32'(theta_valid), 32'(m_tv));
        ck("model_active", 32'(active), 32'(m_active));
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        string        name;
        logic [15:0]  fcw0;
        int           ticks;
        logic [7:0]   exp_theta0;
    } vec_t;

    vec_t vecs [5];

    initial begin
        rst_n  = 1'b0;
        fcw    = '0;
        gate   = '0;
        retrig = '0;

        // Reset behaviour and first-tick latency
        repeat (5) begin
            step();
            ck("reset_theta", 32'(theta), 32'h0);
            ck("reset_valid", 32'(theta_valid), 32'h0);
            ck("reset_active", 32'(active), 32'h0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            step();
            ck("pre_first_tick_valid", 32'(theta_valid), 32'h0);
        end
        step();
        ck("first_tick_valid", 32'(theta_valid), 32'h1);
        repeat (3) step();
        step();
        ck("second_tick_valid", 32'(theta_valid), 32'h1);

        // Constant vectors: accumulate and wrap for player 0 only
        vecs[0] = '{"acc_tick1",   16'h1000, 1,   8'h00};
        vecs[1] = '{"acc_tick15",  16'h1000, 15,  8'h00};
        vecs[2] = '{"acc_tick16",  16'h1000, 16,  8'h01};
        vecs[3] = '{"wrap_tick511",16'h8000, 511, 8'hFF};
        vecs[4] = '{"wrap_tick512",16'h8000, 512, 8'h00};
        for (int v = 0; v < 5; v++) begin
            fcw  = {16'h0123, 16'h0456, vecs[v].fcw0};
            gate = 3'b001;
            do_reset();
            repeat (vecs[v].ticks * DIV) step();
            ck({vecs[v].name, "_theta0"}, 32'(theta[7:0]), 32'(vecs[v].exp_theta0));
            ck({vecs[v].name, "_others"}, 32'(theta[23:8]), 32'h0);
            ck({vecs[v].name, "_active"}, 32'(active), 32'b001);
            ck({vecs[v].name, "_valid"}, 32'(theta_valid), 32'h1);
        end

        // Retrig two cycles before a tick, then coincident with a tick
        fcw = {32'h0, 16'h8000};
        gate = 3'b001;
        do_reset();
        repeat (2 * DIV) step();
        ck("pre_retrig_theta0", 32'(theta[7:0]), 32'h01);
        step();
        retrig = 3'b001;
        step();
        retrig = 3'b000;
        ck("retrig_theta0", 32'(theta[7:0]), 32'h00);
        ck("retrig_no_valid", 32'(theta_valid), 32'h0);
        step();
        step();
        ck("retrig_next_tick_valid", 32'(theta_valid), 32'h1);
        repeat (DIV) step();
        ck("retrig_acc_is_2fcw", 32'(theta[7:0]), 32'h01);
        repeat (DIV - 1) step();
        retrig = 3'b001;
        step();
        retrig = 3'b000;
        ck("retrig_at_tick_theta0", 32'(theta[7:0]), 32'h00);
        ck("retrig_at_tick_valid", 32'(theta_valid), 32'h1);
        repeat (DIV) step();
        ck("retrig_at_tick_acc_zero", 32'(theta[7:0]), 32'h00);

        // fcw change mid-interval and gate drop one cycle before a tick
        fcw = {32'h0, 16'h8000};
        gate = 3'b001;
        do_reset();
        repeat (DIV + 2) step();
        fcw = {32'h0, 16'hC000};
        step();
        step();
        ck("fcw_mid_theta0", 32'(theta[7:0]), 32'h01);
        repeat (DIV - 2) step();
        gate = 3'b000;
        step();
        ck("gate_drop_pre_active", 32'(active), 32'b001);
        step();
        ck("gate_drop_theta0", 32'(theta[7:0]), 32'h00);
        ck("gate_drop_active", 32'(active), 32'b000);

        // Reset mid-operation
        fcw = {32'h0, 16'h5A00};
        gate = 3'b001;
        do_reset();
        repeat (256 * DIV + 2) step();
        ck("mid_reset_pre_theta0", 32'(theta[7:0]), 32'h5A);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ck("mid_reset_theta", 32'(theta), 32'h0);
        ck("mid_reset_valid", 32'(theta_valid), 32'h0);
        ck("mid_reset_active", 32'(active), 32'h0);
        repeat (3) step();
        ck("mid_reset_no_early_valid", 32'(theta_valid), 32'h0);
        step();
        ck("mid_reset_first_valid", 32'(theta_valid), 32'h1);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0)
                fcw = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0)
                gate = PN'($urandom());
            retrig = ($urandom_range(0, 9) == 0) ? PN'($urandom()) : '0;
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
